// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared defaults and drain state encoding for the matrix result drain
package tpu_pkg;

    localparam int ACC_WIDTH_DEF  = 32;
    localparam int LOG2_MAX_N_DEF = 8;
    localparam int MAX_N_DEF      = 256;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } drain_state_e;

endpackage

// File: rtl/matrix_result_drain_if.sv
// rtl/matrix_result_drain_if.sv - row stream from the result drain to writeback
interface matrix_result_drain_if #(
    parameter int N          = 2,
    parameter int ACC_WIDTH  = tpu_pkg::ACC_WIDTH_DEF,
    parameter int LOG2_MAX_N = tpu_pkg::LOG2_MAX_N_DEF
);

    logic                    out_valid;
    logic                    out_ready;
    logic [N*ACC_WIDTH-1:0]  out_row;
    logic [LOG2_MAX_N-1:0]   out_row_idx;
    logic                    out_last;

    modport master (
        output out_valid,
        output out_row,
        output out_row_idx,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_row,
        input  out_row_idx,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/matrix_result_drain_relu.sv
// rtl/matrix_result_drain_relu.sv - per-element capture clamp (acc_relu); active only with DRAIN_RELU_EN
module acc_relu #(
    parameter int ACC_WIDTH = tpu_pkg::ACC_WIDTH_DEF
) (
    input  logic [ACC_WIDTH-1:0] acc_i,
    output logic [ACC_WIDTH-1:0] acc_o
);

`ifdef DRAIN_RELU_EN
    assign acc_o = acc_i[ACC_WIDTH-1] ? '0 : acc_i;
`else
    assign acc_o = acc_i;
`endif

endmodule

// File: rtl/matrix_result_drain.sv
// rtl/matrix_result_drain.sv - snapshots the accumulator array and streams it one row per beat; ReLU via DRAIN_RELU_EN
module matrix_result_drain
    import tpu_pkg::*;
#(
    parameter int N          = 2,
    parameter int MAX_N      = MAX_N_DEF,
    parameter int LOG2_MAX_N = LOG2_MAX_N_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       done,
    input  logic [N*N*ACC_WIDTH-1:0]   C,
    output logic                       busy,
    output logic                       overrun,
    matrix_result_drain_if.master      drain
);

    localparam int                    ROW_W    = N * ACC_WIDTH;
    localparam logic [LOG2_MAX_N-1:0] LAST_IDX = LOG2_MAX_N'(N - 1);

    if (N < 1 || N > MAX_N) begin : g_bad_n
        $error("matrix_result_drain: N out of range");
    end

    drain_state_e                state_q;
    logic [LOG2_MAX_N-1:0]       row_idx_q;
    logic [N*N*ACC_WIDTH-1:0]    buf_q;
    logic [ROW_W-1:0]            out_row_q;
    logic                        out_last_q;
    logic                        overrun_q;

    logic [N*N*ACC_WIDTH-1:0]    c_clamped;
    logic [LOG2_MAX_N-1:0]       next_idx;
    logic                        beat;
    logic                        at_last;
    logic                        capture;

    for (genvar gi = 0; gi < N * N; gi++) begin : g_relu
        acc_relu #(.ACC_WIDTH(ACC_WIDTH)) u_relu (
            .acc_i (C[gi*ACC_WIDTH +: ACC_WIDTH]),
            .acc_o (c_clamped[gi*ACC_WIDTH +: ACC_WIDTH])
        );
    end

    assign beat     = (state_q == ST_DRAIN) && drain.out_ready;
    assign at_last  = (row_idx_q == LAST_IDX);
    assign next_idx = row_idx_q + LOG2_MAX_N'(1);
    // A done pulse is accepted when idle or exactly on the final beat; anything else is an overrun.
    assign capture  = done && ((state_q == ST_IDLE) || (beat && at_last));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            row_idx_q  <= '0;
            buf_q      <= '0;
            out_row_q  <= '0;
            out_last_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else if (capture) begin
            state_q    <= ST_DRAIN;
            buf_q      <= c_clamped;
            row_idx_q  <= '0;
            out_row_q  <= c_clamped[ROW_W-1:0];
            out_last_q <= (N == 1);
        end else if (state_q == ST_DRAIN) begin
            if (done) begin
                overrun_q <= 1'b1;
            end
            if (beat) begin
                if (at_last) begin
                    state_q    <= ST_IDLE;
                    row_idx_q  <= '0;
                    out_last_q <= 1'b0;
                end else begin
                    row_idx_q  <= next_idx;
                    out_row_q  <= buf_q[int'(next_idx)*ROW_W +: ROW_W];
                    out_last_q <= (next_idx == LAST_IDX);
                end
            end
        end
    end

    assign busy              = (state_q == ST_DRAIN);
    assign overrun           = overrun_q;
    assign drain.out_valid   = (state_q == ST_DRAIN);
    assign drain.out_row     = out_row_q;
    assign drain.out_row_idx = row_idx_q;
    assign drain.out_last    = out_last_q;

endmodule

// File: tb/tb_matrix_result_drain.sv
// tb/tb_matrix_result_drain.sv - directed and randomized checks of matrix_result_drain against a row-queue model
module tb_matrix_result_drain;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int LW = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              done = 1'b0;
    logic [N*N*AW-1:0] C = '0;
    logic              busy;
    logic              overrun;

    matrix_result_drain_if #(.N(N), .ACC_WIDTH(AW), .LOG2_MAX_N(LW)) drain_if ();

    matrix_result_drain #(.N(N), .MAX_N(256), .LOG2_MAX_N(LW), .ACC_WIDTH(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .done    (done),
        .C       (C),
        .busy    (busy),
        .overrun (overrun),
        .drain   (drain_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*AW-1:0] row;
        logic [LW-1:0]   idx;
        logic            last;
    } beat_t;

    beat_t q[$];
    logic  overrun_exp = 1'b0;
    int    n_checks = 0;
    int    n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [AW-1:0] model_elem(input logic [AW-1:0] v);
`ifdef DRAIN_RELU_EN
        if ($signed(v) < 0) return '0;
`endif
        return v;
    endfunction

    function automatic logic [N*N*AW-1:0] mk_c(input int a, input int b, input int c, input int d);
        logic [N*N*AW-1:0] m;
        m[0*AW +: AW] = AW'(a);
        m[1*AW +: AW] = AW'(b);
        m[2*AW +: AW] = AW'(c);
        m[3*AW +: AW] = AW'(d);
        return m;
    endfunction

    task automatic model_push(input logic [N*N*AW-1:0] m);
        beat_t b;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) b.row[c*AW +: AW] = model_elem(m[(r*N+c)*AW +: AW]);
            b.idx  = LW'(r);
            b.last = (r == N - 1);
            q.push_back(b);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_valid"}, 128'(drain_if.out_valid), 128'(q.size() > 0));
        chk({tag, "_busy"}, 128'(busy), 128'(q.size() > 0));
        chk({tag, "_overrun"}, 128'(overrun), 128'(overrun_exp));
        chk({tag, "_last"}, 128'(drain_if.out_last), 128'((q.size() > 0) ? q[0].last : 1'b0));
        if (q.size() > 0) begin
            chk({tag, "_row"}, 128'(drain_if.out_row), 128'(q[0].row));
            chk({tag, "_idx"}, 128'(drain_if.out_row_idx), 128'(q[0].idx));
        end
    endtask

    // Drive inputs for one edge, advance the model, then check at the following falling edge.
    task automatic cycle(input string tag, input logic d, input logic rdy, input logic [N*N*AW-1:0] m);
        int  held;
        logic do_beat;
        done = d;
        drain_if.out_ready = rdy;
        C = m;
        held = q.size();
        do_beat = (held > 0) && rdy;
        if (do_beat) void'(q.pop_front());
        if (d) begin
            if (held == 0 || (do_beat && held == 1)) model_push(m);
            else overrun_exp = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        done = 1'b0;
        #1;
        chk({tag, "_rst_valid"}, 128'(drain_if.out_valid), 128'(0));
        chk({tag, "_rst_busy"}, 128'(busy), 128'(0));
        chk({tag, "_rst_overrun"}, 128'(overrun), 128'(0));
        chk({tag, "_rst_row"}, 128'(drain_if.out_row), 128'(0));
        chk({tag, "_rst_idx"}, 128'(drain_if.out_row_idx), 128'(0));
        chk({tag, "_rst_last"}, 128'(drain_if.out_last), 128'(0));
        q.delete();
        overrun_exp = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [N*N*AW-1:0] ca;
        logic [N*N*AW-1:0] cb;
        logic [N*N*AW-1:0] cr;
        logic [N*N*AW-1:0] rnd;
        ca = mk_c(1, 2, 3, 4);
        cb = mk_c(5, 6, 7, 8);
        cr = mk_c(-1, 2, -3, 4);
        drain_if.out_ready = 1'b0;

        @(negedge clk);
        do_reset("init");

        cycle("t1_c0", 1'b1, 1'b1, ca);
        chk("t1_row0_const", 128'(drain_if.out_row), 128'({32'd2, 32'd1}));
        cycle("t1_c1", 1'b0, 1'b1, ca);
        chk("t1_row1_const", 128'(drain_if.out_row), 128'({32'd4, 32'd3}));
        chk("t1_last_const", 128'(drain_if.out_last), 128'(1));
        cycle("t1_c2", 1'b0, 1'b1, ca);
        chk("t1_idle_const", 128'(drain_if.out_valid), 128'(0));

        cycle("t2_cap", 1'b1, 1'b0, ca);
        for (int i = 0; i < 3; i++) cycle("t2_stall", 1'b0, 1'b0, ca);
        chk("t2_held_const", 128'(drain_if.out_row), 128'({32'd2, 32'd1}));
        cycle("t2_b0", 1'b0, 1'b1, ca);
        cycle("t2_b1", 1'b0, 1'b1, ca);

        cycle("t3_cap", 1'b1, 1'b0, ca);
        cycle("t3_ovr", 1'b1, 1'b0, cb);
        chk("t3_ovr_const", 128'(overrun), 128'(1));
        cycle("t3_b0", 1'b0, 1'b1, cb);
        chk("t3_row1_const", 128'(drain_if.out_row), 128'({32'd4, 32'd3}));
        cycle("t3_b1", 1'b0, 1'b1, cb);
        chk("t3_sticky_const", 128'(overrun), 128'(1));

        @(negedge clk);
        do_reset("t4");
        cycle("t4_cap", 1'b1, 1'b1, ca);
        cycle("t4_b0", 1'b0, 1'b1, ca);
        cycle("t4_b2b", 1'b1, 1'b1, cb);
        chk("t4_row_const", 128'(drain_if.out_row), 128'({32'd6, 32'd5}));
        chk("t4_valid_const", 128'(drain_if.out_valid), 128'(1));
        chk("t4_ovr_const", 128'(overrun), 128'(0));
        cycle("t4_b1", 1'b0, 1'b1, cb);
        chk("t4_row1_const", 128'(drain_if.out_row), 128'({32'd8, 32'd7}));
        cycle("t4_end", 1'b0, 1'b1, cb);

        cycle("t5_cap", 1'b1, 1'b1, ca);
        cycle("t5_b0", 1'b0, 1'b1, ca);
        do_reset("t5_mid");
        cycle("t5_recap", 1'b1, 1'b1, cb);
        chk("t5_idx_const", 128'(drain_if.out_row_idx), 128'(0));
        cycle("t5_b0b", 1'b0, 1'b1, cb);
        cycle("t5_end", 1'b0, 1'b1, cb);

        cycle("t6_cap", 1'b1, 1'b1, cr);
`ifdef DRAIN_RELU_EN
        chk("t6_row0_const", 128'(drain_if.out_row), 128'({32'd2, 32'd0}));
`else
        chk("t6_row0_const", 128'(drain_if.out_row), 128'({32'd2, 32'hFFFFFFFF}));
`endif
        cycle("t6_b0", 1'b0, 1'b1, cr);
`ifdef DRAIN_RELU_EN
        chk("t6_row1_const", 128'(drain_if.out_row), 128'({32'd4, 32'd0}));
`else
        chk("t6_row1_const", 128'(drain_if.out_row), 128'({32'd4, 32'hFFFFFFFD}));
`endif
        cycle("t6_end", 1'b0, 1'b1, cr);

        @(negedge clk);
        do_reset("rnd");
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N * N; k++) rnd[k*AW +: AW] = $urandom;
            cycle("rnd", ($urandom % 4) == 0, ($urandom % 3) != 0, rnd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
